muldiv_iter: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EX stage of the five-stage MIPS core, generalising the fixed 32-bit divide path behind `stallreq_for_ex`. It performs signed and unsigned multiply and divide over a configurable operand width with a shift-add / restoring-division datapath. While an operation is in flight it drives a stall request into CTRL. On completion it presents the HI/LO result to the hilo_reg write path.

---
 rtl/muldiv_iter.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned multiply and divide unit for the EX
// stage. One shift-add or restoring-division step per cycle over WIDTH-bit
// operands; HI/LO are registered and change only when a result is delivered.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands and op latched on acceptance
// PREP  | take operand magnitudes, seed accumulator, load counter
// CALC  | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | apply result signs, divide-by-zero override, load hi/lo
// DONE  | done pulse; stall released so EX advances with the result
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             annul,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             stallreq,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    // multiplicand for multiply, divisor magnitude for divide
    logic [WIDTH-1:0]     opnd;
    // multiply: {partial product, remaining multiplier bits}
    // divide:   {partial remainder, remaining dividend / quotient bits}
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 dbz_q;

    logic                 is_div;
    logic                 is_signed;
    logic                 sign_diff;
    logic                 div0;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_part;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign sign_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign div0      = is_div && (b_q == '0);

    // Magnitudes of the latched operands; unsigned ops pass straight through.
    // The most-negative value maps onto itself, which is its correct magnitude
    // when read as unsigned.
    assign abs_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // keep the carry, then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, opnd} & {(WIDTH+1){acc[0]}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The remainder stays below the divisor,
    // so the shifted value needs only one extra bit and the difference fits
    // back into WIDTH bits whenever it is kept.
    assign div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_part >= {1'b0, opnd};
    assign div_rem  = div_part[WIDTH-1:0] - opnd;
    assign div_next = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1}
                             : {acc[2*WIDTH-2:0], 1'b0};

    assign quo_raw = acc[WIDTH-1:0];
    assign rem_raw = acc[2*WIDTH-1:WIDTH];

    // Final result with signs applied; signed overflow simply wraps.
    always_comb begin
        res_hi = rem_raw;
        res_lo = quo_raw;
        if (div0) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (is_div) begin
            res_hi = (is_signed && a_q[WIDTH-1]) ? -rem_raw : rem_raw;
            res_lo = (is_signed && sign_diff)    ? -quo_raw : quo_raw;
        end else begin
            {res_hi, res_lo} = (is_signed && sign_diff) ? -acc : acc;
        end
    end

    // Sequencer and datapath registers; annul aborts from any busy state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            opnd  <= '0;
            acc   <= '0;
            cnt   <= '0;
            dbz_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !annul) begin
                        op_q  <= op;
                        a_q   <= src_a;
                        b_q   <= src_b;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        opnd  <= is_div ? abs_b : abs_a;
                        acc   <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                        cnt   <= CW'(WIDTH - 1);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        if (cnt == '0) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        dbz_q <= div0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    dbz_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign stallreq    = (start && !annul && (state == S_IDLE)) ||
                         (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
    assign done        = (state == S_DONE) && !annul;
    assign div_by_zero = dbz_q && !annul;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Stimulus pushes model results into per-instance queues; monitors pop and
// compare whenever done is presented, including the cycle it arrived in.
module tb_muldiv_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    logic [31:0] last_hi32 = '0;
    logic [31:0] last_lo32 = '0;

    logic        start32, annul32, busy32, stall32, done32, dbz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        start8, annul8, busy8, stall8, done8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    muldiv_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .annul(annul32),
        .src_a(a32), .src_b(b32), .busy(busy32), .stallreq(stall32),
        .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .annul(annul8),
        .src_a(a8), .src_b(b8), .busy(busy8), .stallreq(stall8),
        .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit [63:0] mask, ua, ub, p;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'b0, a} & mask;
        ub = {32'b0, b} & mask;
        sa = a[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = b[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        e.dbz = 1'b0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = ua * ub;
            default: begin
                if (ub == 0) begin
                    e.dbz = 1'b1;
                    p = (ua << w) | mask;
                end else begin
                    if (op == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'(ua / ub);
                        r = longint'(ua % ub);
                    end
                    p = ((64'(r) & mask) << w) | (64'(q) & mask);
                end
            end
        endcase
        e.lo  = 32'(p & mask);
        e.hi  = 32'((p >> w) & mask);
        e.due = 0;
        return e;
    endfunction

    function automatic logic [31:0] rval(input int w);
        logic [31:0] m, v;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = m;
            3: v = 32'h1 << (w - 1);
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    // Monitor for the 32-bit instance: every done must match the queue head.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst === 1'b1 && done32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_unexpected: got done at cycle %0d, expected none", cyc);
            end else begin
                e = q32.pop_front();
                chk("w32_hi", hi32, e.hi);
                chk("w32_lo", lo32, e.lo);
                chk("w32_dbz", {31'b0, dbz32}, {31'b0, e.dbz});
                chk("w32_done_cycle", cyc, e.due);
                last_hi32 = e.hi;
                last_lo32 = e.lo;
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done at cycle %0d, expected none", cyc);
            end else begin
                e = q8.pop_front();
                chk("w8_hi", {24'b0, hi8}, e.hi);
                chk("w8_lo", {24'b0, lo8}, e.lo);
                chk("w8_dbz", {31'b0, dbz8}, {31'b0, e.dbz});
                chk("w8_done_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input bit push, input bit prof, output int t0);
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy32 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("w32_busy_clears", {31'b0, busy32}, 32'h0);
        start32 = 1'b1;
        op32 = o;
        a32 = a;
        b32 = b;
        t0 = cyc;
        if (push) begin
            e = model(32, o, a, b);
            e.due = t0 + 35;
            q32.push_back(e);
        end
        if (prof) begin
            #1;
            chk("stall_c0", {31'b0, stall32}, 32'h1);
        end
        @(negedge clk);
        start32 = 1'b0;
        op32 = 2'($urandom);
        a32 = $urandom;
        b32 = $urandom;
        if (prof) begin
            for (int r = 1; r <= 36; r++) begin
                #1;
                chk($sformatf("stall_c%0d", r), {31'b0, stall32}, {31'b0, (r <= 34)});
                chk($sformatf("busy_c%0d", r), {31'b0, busy32}, {31'b0, (r <= 35)});
                @(negedge clk);
            end
        end
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          output int t0);
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("w8_busy_clears", {31'b0, busy8}, 32'h0);
        start8 = 1'b1;
        op8 = o;
        a8 = a;
        b8 = b;
        t0 = cyc;
        e = model(8, o, {24'b0, a}, {24'b0, b});
        e.due = t0 + 11;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        op8 = 2'($urandom);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0, t1, guard;
        rst = 1'b0;
        start32 = 0; annul32 = 0; op32 = 0; a32 = 0; b32 = 0;
        start8 = 0;  annul8 = 0;  op8 = 0;  a8 = 0;  b8 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy32", {31'b0, busy32}, 32'h0);
        chk("rst_stall32", {31'b0, stall32}, 32'h0);
        chk("rst_done32", {31'b0, done32}, 32'h0);
        chk("rst_dbz32", {31'b0, dbz32}, 32'h0);
        chk("rst_hi32", hi32, 32'h0);
        chk("rst_lo32", lo32, 32'h0);
        chk("rst_busy8", {31'b0, busy8}, 32'h0);
        chk("rst_hilo8", {16'b0, hi8, lo8}, 32'h0);
        rst = 1'b1;

        // Directed results at WIDTH=32.
        issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, t0);
        issue32(2'b00, 32'hFFFF_FFFD, 32'd5, 1, 0, t0);
        issue32(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 0, t0);
        issue32(2'b11, 32'd7, 32'd2, 1, 0, t0);
        issue32(2'b11, 32'h1234_5678, 32'd0, 1, 0, t0);
        issue32(2'b10, 32'h1234_5678, 32'd0, 1, 0, t0);
        issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, t0);

        // start and annul together in IDLE: annul wins.
        @(negedge clk);
        while (busy32) @(negedge clk);
        start32 = 1'b1; annul32 = 1'b1; op32 = 2'b01; a32 = 32'd3; b32 = 32'd3;
        #1;
        chk("annul_idle_stall", {31'b0, stall32}, 32'h0);
        @(negedge clk);
        chk("annul_idle_busy", {31'b0, busy32}, 32'h0);
        start32 = 1'b0; annul32 = 1'b0;

        // annul while in DONE forces done low.
        issue32(2'b11, 32'd100, 32'd9, 0, 0, t0);
        while (cyc != t0 + 34) @(negedge clk);
        @(posedge clk);
        #1 annul32 = 1'b1;
        #1;
        chk("annul_done_pulse", {31'b0, done32}, 32'h0);
        @(posedge clk);
        #1 annul32 = 1'b0;
        @(negedge clk);
        chk("annul_done_idle", {31'b0, busy32}, 32'h0);
        issue32(2'b00, 32'd12345, 32'hFFFF_FF00, 1, 0, t0);

        // annul in cycle 10 of a div: IDLE in cycle 11, hi/lo held, restart in 12.
        issue32(2'b10, 32'hFFFF_0000, 32'd77, 0, 0, t0);
        while (cyc != t0 + 10) @(negedge clk);
        annul32 = 1'b1;
        @(negedge clk);
        annul32 = 1'b0;
        chk("annul_mid_busy", {31'b0, busy32}, 32'h0);
        chk("annul_mid_hi", hi32, last_hi32);
        chk("annul_mid_lo", lo32, last_lo32);
        issue32(2'b10, 32'd1000, 32'hFFFF_FFF9, 1, 0, t1);
        chk("annul_restart_cycle", t1, t0 + 12);

        // Reset in cycle 5 aborts; a following op completes normally.
        issue32(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0, t0);
        while (cyc != t0 + 5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_busy", {31'b0, busy32}, 32'h0);
        chk("rstmid_stall", {31'b0, stall32}, 32'h0);
        chk("rstmid_done", {31'b0, done32}, 32'h0);
        chk("rstmid_hi", hi32, 32'h0);
        chk("rstmid_lo", lo32, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        issue32(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0, t0);

        // Random traffic at WIDTH=32.
        for (int i = 0; i < 40; i++) begin
            issue32(2'($urandom_range(0, 3)), rval(32), rval(32), 1, 0, t0);
        end

        // WIDTH=8: overflow case plus a start presented while busy.
        issue8(2'b10, 8'h80, 8'hFF, t0);
        while (cyc != t0 + 3) @(negedge clk);
        start8 = 1'b1; op8 = 2'b11; a8 = 8'h55; b8 = 8'h03;
        @(negedge clk);
        start8 = 1'b0;
        issue8(2'b11, 8'h12, 8'h00, t0);
        issue8(2'b10, 8'hF9, 8'h02, t0);
        for (int i = 0; i < 30; i++) begin
            issue8(2'($urandom_range(0, 3)), 8'(rval(8)), 8'(rval(8)), t0);
        end

        guard = 0;
        while ((busy32 || busy8) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (40) @(negedge clk);
        chk("q32_drained", q32.size(), 32'h0);
        chk("q8_drained", q8.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
